// File: rtl/sram_pkg.sv
// Shared types and helpers for the parametrised data SRAM.
// Optional per-byte parity storage is enabled with the RAM_PARITY_EN macro.
package sram_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    localparam int BYTE_W = 8;

    // Even parity: the stored bit makes the total count of ones even.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/sram_clear_ctrl.sv
// Sequential clear engine: sweeps every word to zero, one per clock, and
// reports busy while the sweep is in progress.
//
// state | meaning
// IDLE  | array available for accesses; clr_req starts a sweep
// CLEAR | zeroing mem[clr_ptr] each cycle; accesses are ignored
module sram_clear_ctrl
    import sram_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int AW         = 4,
    parameter int INIT_CLEAR = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    localparam state_e        RST_STATE = (INIT_CLEAR != 0) ? CLEAR : IDLE;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        clr_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            CLEAR: begin
                clr_we = 1'b1;
                // A request arriving mid-sweep is dropped; the sweep never restarts.
                if (ptr_q == LAST_ADDR) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    assign busy     = (state_q == CLEAR);
    assign clr_addr = ptr_q;

endmodule

// File: rtl/param_sram.sv
// Single-port synchronous data RAM with byte-lane writes, registered read
// bus, read-valid strobe and a sequential clear engine. Define RAM_PARITY_EN
// for per-byte parity storage with error injection and a parity_err strobe.
module param_sram
    import sram_pkg::*;
#(
    parameter int  DW         = 32,
    parameter int  DEPTH      = 16,
    parameter int  INIT_CLEAR = 1,
    localparam int NB         = DW / BYTE_W,
    localparam int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cs,
    input  logic          wr_en,
    input  logic          rd_en,
    input  logic [NB-1:0] be,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    input  logic          clr_req,
`ifdef RAM_PARITY_EN
    input  logic          par_flip,
    output logic          parity_err,
`endif
    output logic [DW-1:0] rdata,
    output logic          rvalid,
    output logic          busy
);

    logic [DW-1:0] mem [DEPTH];

    logic          busy_w;
    logic          clr_we;
    logic [AW-1:0] clr_addr;

    sram_clear_ctrl #(
        .DEPTH     (DEPTH),
        .AW        (AW),
        .INIT_CLEAR(INIT_CLEAR)
    ) u_clear_ctrl (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_req (clr_req),
        .busy    (busy_w),
        .clr_we  (clr_we),
        .clr_addr(clr_addr)
    );

    logic          acc, in_range, do_wr, do_rd;
    logic [DW-1:0] old_word, merged, rd_word;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          rvalid_q;

    assign acc      = cs && !busy_w;
    // Only non-power-of-two depths can present an address past the array.
    assign in_range = (32'(addr) < DEPTH);
    assign do_wr    = acc && wr_en && in_range;
    assign do_rd    = acc && rd_en;
    assign old_word = in_range ? mem[addr] : '0;

    always_comb begin
        merged = old_word;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) merged[i*BYTE_W +: BYTE_W] = wdata[i*BYTE_W +: BYTE_W];
        end
    end

    // Write-first: a combined write+read returns the merged word.
    assign rd_word = wr_en ? merged : old_word;

    always_comb begin
        rdata_d = rdata_q;
        if (do_rd) rdata_d = in_range ? rd_word : '0;
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (do_wr) begin
            mem[addr] <= merged;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= do_rd;
        end
    end

`ifdef RAM_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];
    logic [NB-1:0] old_par, wr_par, merged_par, rd_par, par_mis;
    logic          perr_q, perr_d;

    assign old_par = in_range ? par_mem[addr] : '0;

    always_comb begin
        wr_par     = '0;
        merged_par = old_par;
        for (int i = 0; i < NB; i++) begin
            wr_par[i] = byte_parity(wdata[i*BYTE_W +: BYTE_W]) ^ par_flip;
            if (be[i]) merged_par[i] = wr_par[i];
        end
    end

    assign rd_par = wr_en ? merged_par : old_par;

    always_comb begin
        par_mis = '0;
        for (int i = 0; i < NB; i++) begin
            par_mis[i] = byte_parity(rd_word[i*BYTE_W +: BYTE_W]) ^ rd_par[i];
        end
    end

    assign perr_d = do_rd && in_range && (|par_mis);

    always_ff @(posedge clk) begin
        if (clr_we) begin
            par_mem[clr_addr] <= '0;
        end else if (do_wr) begin
            par_mem[addr] <= merged_par;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign parity_err = perr_q;
`endif

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign busy   = busy_w;

endmodule

// File: doc/param_sram.md
Name: param_sram

Overview:
- Parametrised single-port synchronous data memory. It is the successor to the fixed 16x4 scratch memory and serves as the pipelined CPU's data RAM.
- Adds:
  - configurable width and depth
  - byte-lane write enables
  - a read-valid strobe
  - a held, non-tristated read bus
  - a sequential clear engine that replaces the single-cycle reset-clear
- Sits between the MEM stage and the bus. The MEM stage must stall while busy=1.

Parameters:
- DW, 32: data width in bits; must be a multiple of 8. NB=DW/8 byte lanes (localparam).
- DEPTH, 16: number of words; need not be a power of two. AW=$clog2(DEPTH) (localparam, min 1).
- INIT_CLEAR, 1: 1 = clear engine runs automatically on reset release; 0 = memory is undefined after reset.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cs  in  1  chip select; no access is accepted when 0
- wr_en  in  1  write request
- rd_en  in  1  read request
- be  in  NB  byte-lane write enables; bit i covers wdata[8i+7:8i]
- addr  in  AW  word address
- wdata  in  DW  write data
- clr_req  in  1  single-cycle request to zero the whole array
- rdata  out  DW  read data, registered
- rvalid  out  1  one-cycle strobe: rdata was updated this cycle
- busy  out  1  clear engine active; accesses ignored
- parity_err  out  1  present only with RAM_PARITY_EN
- par_flip  in  1  present only with RAM_PARITY_EN

Behaviour:
- Reset (rst_n=0, asynchronous):
  - rdata=0, rvalid=0, clr_ptr=0
  - state=CLEAR if INIT_CLEAR=1, else IDLE
  - busy is decoded combinationally from state, so busy=INIT_CLEAR while in reset
  - array contents are not touched by reset itself
- State machine IDLE/CLEAR:
  - IDLE: clr_req=1 at an edge -> CLEAR, clr_ptr=0.
  - CLEAR: each edge writes mem[clr_ptr]=0 and increments clr_ptr.
  - On the edge that writes DEPTH-1 -> IDLE. The clear therefore takes exactly DEPTH cycles.
  - clr_req during CLEAR is ignored; there is no restart.
  - Reset mid-clear aborts the sweep and restarts at 0 when INIT_CLEAR=1.
- Access condition: an access is accepted at an edge only when state=IDLE and cs=1. When busy=1, cs/wr_en/rd_en are ignored: no write, rvalid=0, rdata held.
- Write (wr_en=1):
  - mem[addr] byte i <= wdata byte i for each be[i]=1; other lanes are unchanged.
  - be=0 is a legal no-op write.
- Read (rd_en=1, wr_en=0):
  - rdata <= mem[addr] at the edge; rvalid=1 for the following cycle only.
  - Latency: 1 cycle.
- Simultaneous wr_en and rd_en: write-first.
  - rdata <= merged word: new bytes where be=1, old bytes elsewhere.
  - rvalid=1.
- Without a read, rdata holds its last value and rvalid=0. The output is never Z.
- Out-of-range addr (addr>=DEPTH, only possible for non-power-of-two DEPTH):
  - write is dropped
  - read returns 0 with rvalid=1
- Back-to-back reads are accepted every cycle.
- clr_req in the same cycle as an accepted access: the access completes at that edge, and CLEAR begins from the next edge.

Optional Feature:
- Macro RAM_PARITY_EN.
- When defined:
  - each word stores NB extra even-parity bits, one per byte, computed on write
  - if par_flip=1 on a write, the stored parity of every written lane is inverted (error injection)
  - on a read, parity is recomputed; parity_err is registered alongside rdata and pulses with rvalid if any lane mismatches
  - the clear engine writes correct parity (0)
  - parity_err resets to 0
- When undefined: the par_flip and parity_err ports and the parity storage are absent; behaviour is otherwise identical.

Decomposition:
- Package sram_pkg contains:
  - state typedef (IDLE, CLEAR)
  - localparam BYTE_W=8
  - function byte_parity(input [7:0])
- One sub-module: sram_clear_ctrl. It contains the FSM and clr_ptr, and outputs busy, clr_we and clr_addr.
- The array, byte merge and read register stay in param_sram.

Test Plan:
- Reset release, INIT_CLEAR=1, DEPTH=16 -> busy=1 for exactly 16 cycles after release. Then read addr 0..15 -> rdata=0, with rvalid one cycle after each request.
- Write addr 9 = 0xDEADBEEF with be=4'b1111, then write addr 9 with wdata=0x00000011 and be=4'b0001, then read addr 9 -> rdata=0xDEADBE11 after 1 cycle.
- Same-cycle wr_en+rd_en to addr 3: old word 0x11223344, wdata=0xAABBCCDD, be=4'b1100 -> rdata=0xAABB3344, rvalid=1 next cycle.
- clr_req pulse, then an attempted write of addr 5=0xFFFFFFFF during busy -> write ignored, rvalid=0, rdata held. After the clear, read addr 5 -> 0.
- Assert rst_n=0 at clr_ptr=7 of a clear -> rdata=0 immediately. After release, busy is 1 for a full 16 cycles again.
- DEPTH=12, write addr 13, then read addr 13 -> rdata=0, rvalid=1. With RAM_PARITY_EN: write with par_flip=1, then read -> parity_err=1 with rvalid; a clean write then read -> parity_err=0.
